// File: rtl/fpga_cfg_pkg.sv
// Shared types and helpers for the FPGA configuration path.
package fpga_cfg_pkg;

    // Configuration sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_KICK   = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_RUN    = 3'd4,
        ST_ERROR  = 3'd5
    } t_cfg_seq_state;

    // Width of a CLB index; never narrower than one bit.
    function automatic int clb_idx_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_stream_if.sv
// Minimal AXI-Stream bundle carrying the configuration bitstream.
interface axi_stream_if #(
    parameter int DATA_WIDTH = 1
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/clb_cfg_sequencer_stall_watchdog.sv
// Stall watchdog: counts consecutive cycles while clear is low and flags
// the cycle in which the count reaches LIMIT.
module stall_watchdog #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic expired
);
    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] count;

    // Stall counter, saturating at LIMIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count != CNT_W'(LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    // Asserted during the stall cycle that brings the count to LIMIT, so the
    // consumer leaves on the same edge that the counter reaches it.
    assign expired = !clear && (count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/clb_cfg_sequencer.sv
// Configuration sequencer for the CLB array: steers one upstream bitstream
// into each CLB in index order, pulses its cfg, waits for cfg_ready, and
// raises run when every CLB is configured.
// Optional stall timeout: define CLB_CFG_SEQ_TIMEOUT_EN.
module clb_cfg_sequencer
    import fpga_cfg_pkg::*;
#(
    parameter int NUM_CLBS             = 4,
    parameter int BITSTREAM_DATA_WIDTH = 1,
    parameter int TIMEOUT_CYCLES       = 1024
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    axi_stream_if.slave                         bitstream,
    output logic [NUM_CLBS-1:0]                 clb_tvalid,
    output logic [BITSTREAM_DATA_WIDTH-1:0]     clb_tdata,
    output logic                                clb_tlast,
    input  logic [NUM_CLBS-1:0]                 clb_tready,
    output logic [NUM_CLBS-1:0]                 clb_cfg,
    input  logic [NUM_CLBS-1:0]                 clb_cfg_ready,
    output logic                                clb_run,
    output logic                                cfg_busy,
    output logic                                cfg_error,
    output logic [clb_idx_w(NUM_CLBS)-1:0]      clb_idx
);
    localparam int                IDX_W    = clb_idx_w(NUM_CLBS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_CLBS - 1);

    t_cfg_seq_state      state;
    t_cfg_seq_state      state_next;
    logic [IDX_W-1:0]    idx_next;
    logic                mask_ready;     // high in the first STREAM cycle after KICK
    logic [NUM_CLBS-1:0] sel;            // one-hot of the selected CLB
    logic                sel_tready;
    logic                sel_cfg_ready;
    logic                in_stream;
    logic                beat;
    logic                done;
    logic                early_last;
    logic                timeout;

    assign sel           = NUM_CLBS'(1) << clb_idx;
    assign sel_tready    = |(clb_tready & sel);
    assign sel_cfg_ready = |(clb_cfg_ready & sel);
    assign in_stream     = (state == ST_STREAM);
    assign beat          = in_stream && bitstream.tvalid && sel_tready;
    assign done          = in_stream && !mask_ready && sel_cfg_ready;
    assign early_last    = beat && bitstream.tlast && (clb_idx != LAST_IDX);

`ifdef CLB_CFG_SEQ_TIMEOUT_EN
    // Any cycle outside STREAM, or with progress, restarts the stall count.
    logic stall_clear;
    assign stall_clear = !in_stream || beat || done;

    stall_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_stall_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (stall_clear),
        .expired (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    // State, index and ready-mask registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            clb_idx    <= '0;
            mask_ready <= 1'b0;
        end else begin
            state      <= state_next;
            clb_idx    <= idx_next;
            mask_ready <= (state == ST_KICK);
        end
    end

    // Next-state and next-index logic.
    // NOTE: defaults come first so every path assigns every signal and no
    // latch is inferred.
    always_comb begin
        state_next = state;
        idx_next   = clb_idx;
        unique case (state)
            ST_IDLE, ST_RUN, ST_ERROR: begin
                if (start) begin
                    state_next = ST_KICK;
                    idx_next   = '0;
                end
            end
            ST_KICK: begin
                state_next = ST_STREAM;
            end
            ST_STREAM: begin
                if (early_last || timeout) begin
                    state_next = ST_ERROR;
                end else if (done) begin
                    if (clb_idx == LAST_IDX) begin
                        state_next = ST_DRAIN;
                    end else begin
                        state_next = ST_KICK;
                        idx_next   = clb_idx + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                state_next = ST_RUN;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Stream routing and status outputs, decoded from the current state.
    always_comb begin
        clb_tvalid       = '0;
        clb_cfg          = '0;
        bitstream.tready = 1'b0;
        if (in_stream) begin
            clb_tvalid       = bitstream.tvalid ? sel : '0;
            bitstream.tready = sel_tready;
        end
        if (state == ST_KICK) begin
            clb_cfg = sel;
        end
    end

    assign clb_tdata = bitstream.tdata;
    assign clb_tlast = bitstream.tlast;
    assign clb_run   = (state == ST_RUN);
    assign cfg_error = (state == ST_ERROR);
    assign cfg_busy  = (state == ST_KICK) || in_stream || (state == ST_DRAIN);

endmodule

// File: tb/tb_clb_cfg_sequencer.sv
// Self-checking bench for clb_cfg_sequencer with two CLBs and an 8-bit stream.
module tb_clb_cfg_sequencer;

    localparam int N  = 2;
    localparam int DW = 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [N-1:0]  clb_tvalid;
    logic [DW-1:0] clb_tdata;
    logic          clb_tlast;
    logic [N-1:0]  clb_tready = '0;
    logic [N-1:0]  clb_cfg;
    logic [N-1:0]  clb_cfg_ready = '0;
    logic          clb_run;
    logic          cfg_busy;
    logic          cfg_error;
    logic [0:0]    clb_idx;

    int compared   = 0;
    int mismatched = 0;

    axi_stream_if #(.DATA_WIDTH(DW)) bs_if ();

    clb_cfg_sequencer #(
        .NUM_CLBS             (N),
        .BITSTREAM_DATA_WIDTH (DW),
        .TIMEOUT_CYCLES       (TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .bitstream     (bs_if),
        .clb_tvalid    (clb_tvalid),
        .clb_tdata     (clb_tdata),
        .clb_tlast     (clb_tlast),
        .clb_tready    (clb_tready),
        .clb_cfg       (clb_cfg),
        .clb_cfg_ready (clb_cfg_ready),
        .clb_run       (clb_run),
        .cfg_busy      (cfg_busy),
        .cfg_error     (cfg_error),
        .clb_idx       (clb_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         start;
        logic         tvalid;
        logic         tlast;
        logic [7:0]   tdata;
        logic [1:0]   c_tready;
        logic [1:0]   c_ready;
        logic [1:0]   e_tvalid;
        logic         e_tready;
        logic [1:0]   e_cfg;
        logic         e_run;
        logic         e_busy;
        logic         e_err;
        logic         e_idx;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic s, input logic tv, input logic tl, input logic [7:0] td,
                       input logic [1:0] ctr, input logic [1:0] crd,
                       input logic [1:0] etv, input logic etr, input logic [1:0] ecfg,
                       input logic erun, input logic ebusy, input logic eerr, input logic eidx);
        vec_t v;
        v = '{s, tv, tl, td, ctr, crd, etv, etr, ecfg, erun, ebusy, eerr, eidx};
        vecs.push_back(v);
    endtask

    // Advance one clock, apply inputs just after the edge, settle at negedge.
    task automatic cycle(input logic s, input logic tv, input logic tl, input logic [7:0] td,
                         input logic [1:0] ctr, input logic [1:0] crd);
        @(posedge clk);
        #1;
        start         = s;
        bs_if.tvalid  = tv;
        bs_if.tlast   = tl;
        bs_if.tdata   = td;
        clb_tready    = ctr;
        clb_cfg_ready = crd;
        @(negedge clk);
    endtask

    task automatic check_all(input string tag, input logic [1:0] etv, input logic etr,
                             input logic [1:0] ecfg, input logic erun, input logic ebusy,
                             input logic eerr, input logic eidx);
        check({tag, ".clb_tvalid"}, 32'(clb_tvalid), 32'(etv));
        check({tag, ".tready"},     32'(bs_if.tready), 32'(etr));
        check({tag, ".clb_cfg"},    32'(clb_cfg), 32'(ecfg));
        check({tag, ".clb_run"},    32'(clb_run), 32'(erun));
        check({tag, ".cfg_busy"},   32'(cfg_busy), 32'(ebusy));
        check({tag, ".cfg_error"},  32'(cfg_error), 32'(eerr));
        check({tag, ".clb_idx"},    32'(clb_idx), 32'(eidx));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n         = 1'b0;
        start         = 1'b0;
        bs_if.tvalid  = 1'b0;
        bs_if.tlast   = 1'b0;
        bs_if.tdata   = '0;
        clb_tready    = '0;
        clb_cfg_ready = '0;
        #3;
        check_all("reset", 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Global time limit so the bench always ends on its own.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "time limit");
    end

    initial begin
        int beats_pass1;
        bs_if.tvalid = 1'b0;
        bs_if.tlast  = 1'b0;
        bs_if.tdata  = '0;

        // Main pass: CLB0 takes 3 beats (with backpressure and a stale masked
        // ready), CLB1 takes 5 beats; then RUN, restart, start ignored mid-pass.
        //  st tv tl data  ctr    crd    etv    etr  ecfg  run busy err idx
        add(0, 0, 0, 8'h00, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0, 0); // IDLE
        add(1, 0, 0, 8'h00, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0, 0); // IDLE, start
        add(0, 1, 0, 8'hAA, 2'b01, 2'b00, 2'b00, 0, 2'b01, 0, 1, 0, 0); // KICK 0
        add(0, 1, 0, 8'h11, 2'b01, 2'b01, 2'b01, 1, 2'b00, 0, 1, 0, 0); // beat1, ready masked
        add(0, 1, 0, 8'h22, 2'b00, 2'b00, 2'b01, 0, 2'b00, 0, 1, 0, 0); // backpressure
        add(0, 1, 0, 8'h22, 2'b01, 2'b00, 2'b01, 1, 2'b00, 0, 1, 0, 0); // beat2
        add(0, 1, 0, 8'h33, 2'b01, 2'b01, 2'b01, 1, 2'b00, 0, 1, 0, 0); // beat3 + done
        add(0, 0, 0, 8'h00, 2'b10, 2'b00, 2'b00, 0, 2'b10, 0, 1, 0, 1); // KICK 1
        add(0, 1, 0, 8'h44, 2'b10, 2'b00, 2'b10, 1, 2'b00, 0, 1, 0, 1); // beat1
        add(0, 1, 0, 8'h55, 2'b11, 2'b00, 2'b10, 1, 2'b00, 0, 1, 0, 1); // beat2
        add(0, 1, 0, 8'h66, 2'b10, 2'b00, 2'b10, 1, 2'b00, 0, 1, 0, 1); // beat3
        add(0, 1, 0, 8'h77, 2'b10, 2'b00, 2'b10, 1, 2'b00, 0, 1, 0, 1); // beat4
        add(0, 1, 1, 8'h88, 2'b10, 2'b10, 2'b10, 1, 2'b00, 0, 1, 0, 1); // beat5 + done
        add(0, 1, 0, 8'h99, 2'b10, 2'b10, 2'b00, 0, 2'b00, 0, 1, 0, 1); // DRAIN
        add(0, 0, 0, 8'h00, 2'b10, 2'b10, 2'b00, 0, 2'b00, 1, 0, 0, 1); // RUN
        add(0, 0, 0, 8'h00, 2'b00, 2'b00, 2'b00, 0, 2'b00, 1, 0, 0, 1); // RUN
        add(1, 0, 0, 8'h00, 2'b00, 2'b00, 2'b00, 0, 2'b00, 1, 0, 0, 1); // RUN, start
        add(0, 0, 0, 8'h00, 2'b00, 2'b00, 2'b00, 0, 2'b01, 0, 1, 0, 0); // KICK 0, run drops
        add(1, 1, 0, 8'h12, 2'b01, 2'b00, 2'b01, 1, 2'b00, 0, 1, 0, 0); // start ignored
        add(1, 1, 0, 8'h13, 2'b01, 2'b01, 2'b01, 1, 2'b00, 0, 1, 0, 0); // done
        add(1, 0, 0, 8'h00, 2'b00, 2'b00, 2'b00, 0, 2'b10, 0, 1, 0, 1); // KICK 1, start ignored

        do_reset();
        beats_pass1 = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            cycle(vecs[i].start, vecs[i].tvalid, vecs[i].tlast, vecs[i].tdata,
                  vecs[i].c_tready, vecs[i].c_ready);
            tag = $sformatf("vec%0d", i);
            check_all(tag, vecs[i].e_tvalid, vecs[i].e_tready, vecs[i].e_cfg,
                      vecs[i].e_run, vecs[i].e_busy, vecs[i].e_err, vecs[i].e_idx);
            check({tag, ".clb_tdata"}, 32'(clb_tdata), 32'(vecs[i].tdata));
            check({tag, ".clb_tlast"}, 32'(clb_tlast), 32'(vecs[i].tlast));
            if (i <= 13 && bs_if.tvalid && bs_if.tready) beats_pass1++;
        end
        check("pass1.beats", 32'(beats_pass1), 32'd8);

        // Stale ready on CLB1 held high from KICK onward.
        do_reset();
        cycle(1, 0, 0, 8'h00, 2'b00, 2'b00);
        cycle(0, 0, 0, 8'h00, 2'b00, 2'b00);
        check_all("stale.kick0", 2'b00, 0, 2'b01, 0, 1, 0, 0);
        cycle(0, 0, 0, 8'h00, 2'b00, 2'b01);
        cycle(0, 1, 0, 8'h05, 2'b01, 2'b01);
        check_all("stale.s0b", 2'b01, 1, 2'b00, 0, 1, 0, 0);
        cycle(0, 0, 0, 8'h00, 2'b00, 2'b10);
        check_all("stale.kick1", 2'b00, 0, 2'b10, 0, 1, 0, 1);
        cycle(0, 1, 0, 8'h06, 2'b10, 2'b10);
        check_all("stale.s1a", 2'b10, 1, 2'b00, 0, 1, 0, 1);
        cycle(0, 1, 0, 8'h07, 2'b10, 2'b10);
        check_all("stale.s1b", 2'b10, 1, 2'b00, 0, 1, 0, 1);
        cycle(0, 1, 0, 8'h08, 2'b10, 2'b10);
        check_all("stale.drain", 2'b00, 0, 2'b00, 0, 1, 0, 1);
        cycle(0, 0, 0, 8'h00, 2'b10, 2'b10);
        check_all("stale.run", 2'b00, 0, 2'b00, 1, 0, 0, 1);

        // Early tlast on beat 2 of CLB0, then recovery through start.
        do_reset();
        cycle(1, 0, 0, 8'h00, 2'b00, 2'b00);
        cycle(0, 0, 0, 8'h00, 2'b00, 2'b00);
        cycle(0, 1, 0, 8'h01, 2'b01, 2'b00);
        cycle(0, 1, 1, 8'h02, 2'b01, 2'b00);
        check_all("tlast.beat2", 2'b01, 1, 2'b00, 0, 1, 0, 0);
        cycle(0, 1, 0, 8'h03, 2'b11, 2'b11);
        check_all("tlast.err", 2'b00, 0, 2'b00, 0, 0, 1, 0);
        cycle(0, 0, 0, 8'h00, 2'b00, 2'b00);
        check_all("tlast.sticky", 2'b00, 0, 2'b00, 0, 0, 1, 0);
        cycle(1, 0, 0, 8'h00, 2'b00, 2'b00);
        check("tlast.err_at_start", 32'(cfg_error), 32'd1);
        cycle(0, 0, 0, 8'h00, 2'b00, 2'b00);
        check_all("tlast.rekick", 2'b00, 0, 2'b01, 0, 1, 0, 0);

        // Asynchronous reset while streaming CLB1.
        do_reset();
        cycle(1, 0, 0, 8'h00, 2'b00, 2'b00);
        cycle(0, 0, 0, 8'h00, 2'b00, 2'b00);
        cycle(0, 1, 0, 8'h01, 2'b01, 2'b01);
        cycle(0, 1, 0, 8'h02, 2'b01, 2'b01);
        cycle(0, 0, 0, 8'h00, 2'b10, 2'b00);
        cycle(0, 1, 0, 8'h03, 2'b10, 2'b00);
        check_all("rst.pre", 2'b10, 1, 2'b00, 0, 1, 0, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check_all("rst.mid", 2'b00, 0, 2'b00, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(0, 1, 0, 8'h04, 2'b11, 2'b11);
        check_all("rst.after", 2'b00, 0, 2'b00, 0, 0, 0, 0);

        // Stalled stream: timeout when enabled, indefinite wait otherwise.
        do_reset();
        cycle(1, 0, 0, 8'h00, 2'b00, 2'b00);
        cycle(0, 0, 0, 8'h00, 2'b00, 2'b00);
`ifdef CLB_CFG_SEQ_TIMEOUT_EN
        for (int s = 1; s <= 10; s++) begin
            cycle(0, 0, 0, 8'h00, 2'b01, 2'b00);
            check($sformatf("to.pre%0d.busy", s), 32'(cfg_busy), 32'd1);
        end
        cycle(0, 1, 0, 8'h09, 2'b01, 2'b00);
        check("to.beat.tready", 32'(bs_if.tready), 32'd1);
        for (int s = 1; s <= TO; s++) begin
            cycle(0, 0, 0, 8'h00, 2'b01, 2'b00);
            check($sformatf("to.stall%0d.err", s), 32'(cfg_error), 32'd0);
            check($sformatf("to.stall%0d.busy", s), 32'(cfg_busy), 32'd1);
        end
        cycle(0, 0, 0, 8'h00, 2'b01, 2'b00);
        check_all("to.err", 2'b00, 0, 2'b00, 0, 0, 1, 0);
`else
        for (int s = 1; s <= 40; s++) begin
            cycle(0, 0, 0, 8'h00, 2'b01, 2'b00);
            check($sformatf("wait%0d.err", s), 32'(cfg_error), 32'd0);
            check($sformatf("wait%0d.busy", s), 32'(cfg_busy), 32'd1);
        end
        cycle(0, 1, 0, 8'h0F, 2'b01, 2'b00);
        check_all("wait.beat", 2'b01, 1, 2'b00, 0, 1, 0, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
